rfft_seq: RTL and testbench

RFFT_SEQ -- requirements
Module: rfft_seq

---
 rtl/rfft_pkg.sv | 15 +
 rtl/rfft_wb_delay.sv | 27 ++
 rtl/rfft_seq.sv | 134 +++++++++++++
 tb/tb_rfft_seq.sv | 139 +++++++++++++
 4 files changed

// File: rtl/rfft_pkg.sv
// rfft_pkg: state encoding, fixed datapath selects and bank read-offset helper for rfft_seq.
package rfft_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, READ, DRAIN, DONE} state_e;
  localparam logic       M11_SEL = 1'b0;
  localparam logic [1:0] M12_SEL = 2'd1;
  localparam logic [1:0] M13_SEL = 2'd1;
  localparam logic       M14_SEL = 1'b1;
  localparam logic       M21_SEL = 1'b0;
  localparam logic       M22_SEL = 1'b0;
  localparam logic       M23_SEL = 1'b1;
  localparam logic       M24_SEL = 1'b1;
  function automatic int off(input int s, input int h);
    return (s < 2) ? 0 : h - (h >> (s - 1));
  endfunction
endpackage

// File: rtl/rfft_wb_delay.sv
// rfft_wb_delay: LAT-deep shift register carrying the write enable and write address
// from the read side of the datapath to its write-back side.
module rfft_wb_delay #(
  parameter int W   = 6,
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we_i,
  input  logic [W-1:0] addr_i,
  output logic         we_o,
  output logic [W-1:0] addr_o
);
  logic [LAT-1:0]   we_q;
  logic [LAT*W-1:0] addr_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q   <= '0;
      addr_q <= '0;
    end else begin
      we_q   <= LAT'({we_q, we_i});
      addr_q <= (LAT*W)'({addr_q, addr_i});
    end
  end
  assign we_o   = we_q[LAT-1];
  assign addr_o = addr_q[(LAT-1)*W +: W];
endmodule

// File: rtl/rfft_seq.sv
// rfft_seq: address/control sequencer for an in-place radix-4 real FFT over four memory banks.
// Define RFFT_SEQ_BITREV_EN to bit-reverse the final-stage write addresses.
module rfft_seq
  import rfft_pkg::*;
#(
  parameter int N        = 256,
  parameter int ADDR_BIT = 6,
  parameter int PIPE_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            stage,
  output logic [ADDR_BIT-1:0]   ld_idx,
  output logic                  en,
  output logic                  re,
  output logic                  we,
  output logic [4*ADDR_BIT-1:0] addr_read,
  output logic [4*ADDR_BIT-1:0] addr_write,
  output logic                  m0,
  output logic                  m11,
  output logic [1:0]            m12,
  output logic [1:0]            m13,
  output logic                  m14,
  output logic                  m21,
  output logic                  m22,
  output logic                  m23,
  output logic                  m24,
  output logic                  bypass_en,
  output logic [ADDR_BIT:0]     tw_idx
);
  localparam int H = N / 4;
  localparam int S = $clog2(N);
  localparam logic [ADDR_BIT-1:0] CNT_LAST   = ADDR_BIT'(H - 1);
  localparam logic [2:0]          DRAIN_LAST = 3'(PIPE_LAT - 1);
  localparam logic [3:0]          STAGE_LAST = 4'(S - 1);
  localparam logic [3:0]          BYP_LIM    = 4'(S / 2);
  state_e              state_q, state_d;
  logic [ADDR_BIT-1:0] cnt_q, cnt_d;
  logic [2:0]          dcnt_q, dcnt_d;
  logic [3:0]          stage_q, stage_d;
  logic [ADDR_BIT-1:0] rd_off, dl_addr, wb_addr;
  logic                dl_we, ld, rd, act;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      stage_q <= stage_d;
    end
  end
  // cnt wraps naturally at H; only the DRAIN exit advances the stage
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    stage_d = stage_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        cnt_d   = '0;
        stage_d = '0;
      end
      LOAD: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CNT_LAST) ? READ : LOAD;
      end
      READ: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CNT_LAST) ? DRAIN : READ;
      end
      DRAIN: begin
        dcnt_d = dcnt_q + 1'b1;
        if (dcnt_q == DRAIN_LAST) begin
          dcnt_d  = '0;
          state_d = (stage_q == STAGE_LAST) ? DONE : READ;
          stage_d = (stage_q == STAGE_LAST) ? stage_q : stage_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        stage_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  assign ld  = state_q == LOAD;
  assign rd  = state_q == READ;
  assign act = rd || state_q == DRAIN;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign stage     = stage_q;
  assign en        = ld || act;
  assign re        = rd;
  assign ld_idx    = ld ? cnt_q : '0;
  assign rd_off    = ADDR_BIT'(off(int'(stage_q), H));
  assign addr_read = rd ? {4{cnt_q + rd_off}} : '0;
  assign tw_idx    = rd ? ({1'b0, cnt_q} << stage_q) : '0;
  assign bypass_en = busy && stage_q < BYP_LIM;
  assign m0  = act;
  assign m11 = act & M11_SEL;
  assign m12 = act ? M12_SEL : 2'd0;
  assign m13 = act ? M13_SEL : 2'd0;
  assign m14 = act & M14_SEL;
  assign m21 = act & M21_SEL;
  assign m22 = act & M22_SEL;
  assign m23 = act & M23_SEL;
  assign m24 = act & M24_SEL;
  rfft_wb_delay #(.W(ADDR_BIT), .LAT(PIPE_LAT)) u_wb_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (rd),
    .addr_i (cnt_q),
    .we_o   (dl_we),
    .addr_o (dl_addr)
  );
`ifdef RFFT_SEQ_BITREV_EN
  always_comb begin
    for (int i = 0; i < ADDR_BIT; i++)
      wb_addr[i] = (stage_q == STAGE_LAST) ? dl_addr[ADDR_BIT-1-i] : dl_addr[i];
  end
`else
  assign wb_addr = dl_addr;
`endif
  assign we         = ld || dl_we;
  assign addr_write = {4{ld ? cnt_q : wb_addr}};
endmodule

// File: tb/tb_rfft_seq.sv
// tb_rfft_seq: cycle model of the rfft_seq schedule with a write-back scoreboard and read-side probe table.
module tb_rfft_seq;
  localparam int N = 256, AB = 6, PL = 2, H = 64, S = 8;
  localparam int LAST = H + S * (H + PL);
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic busy, done, en, re, we, m0, m11, m14, m21, m22, m23, m24, bypass_en;
  logic [1:0] m12, m13;
  logic [3:0] stage;
  logic [AB-1:0] ld_idx;
  logic [4*AB-1:0] addr_read, addr_write;
  logic [AB:0] tw_idx;
  rfft_seq #(.N(N), .ADDR_BIT(AB), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .stage(stage),
    .ld_idx(ld_idx), .en(en), .re(re), .we(we), .addr_read(addr_read), .addr_write(addr_write),
    .m0(m0), .m11(m11), .m12(m12), .m13(m13), .m14(m14), .m21(m21), .m22(m22), .m23(m23),
    .m24(m24), .bypass_en(bypass_en), .tw_idx(tw_idx)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  typedef struct {int stg; int cnt; int ar; int tw; int byp;} vec_t;
  typedef struct {int due; int addr;} wr_t;
  vec_t tbl[10];
  wr_t sb[$];
  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [4*AB-1:0] rep(input int a);
    return {4{AB'(a)}};
  endfunction
  function automatic int exp_wa(input int stg, input int c);
    int r = 0;
`ifdef RFFT_SEQ_BITREV_EN
    if (stg == S - 1) begin
      for (int i = 0; i < AB; i++) if (c[i]) r |= 1 << (AB - 1 - i);
      return r;
    end
`endif
    r = c;
    return r;
  endfunction
  // one transform; optional extra start pulse at cycle start_at, optional reset at cycle abort_at
  task automatic run(input int start_at, input int abort_at);
    int stg, cnt;
    bit ld, rd, dr, dn, idle;
    sb.delete();
    @(negedge clk);
    chk("idle_busy", busy, 0);
    start = 1'b1;
    for (int j = 1; j <= LAST + 2; j++) begin
      @(negedge clk);
      if (j == 1 || j == start_at + 1) start = 1'b0;
      ld = j <= H; rd = 0; dr = 0; stg = 0; cnt = 0;
      if (ld) cnt = j - 1;
      else if (j <= LAST) begin
        stg = (j - H - 1) / (H + PL);
        cnt = (j - H - 1) % (H + PL);
        rd = cnt < H;
        dr = !rd;
        if (dr) cnt = 0;
      end
      dn = j == LAST + 1;
      idle = j > LAST + 1;
      chk("busy", busy, !idle);
      chk("done", done, dn);
      chk("re", re, rd);
      chk("en", en, ld || rd || dr);
      if (!dn) chk("stage", stage, stg);
      if (ld) begin
        chk("ld_idx", ld_idx, cnt);
        chk("we_load", we, 1);
        chk("addr_load", addr_write, rep(cnt));
      end else if (sb.size() > 0 && sb[0].due == j) begin
        chk("we_wb", we, 1);
        chk("addr_wb", addr_write, rep(sb[0].addr));
        void'(sb.pop_front());
      end else chk("we_quiet", we, 0);
      if (rd) begin
        chk("sel", {m0, m11, m12, m13, m14, m21, m22, m23, m24}, 11'b1_0_01_01_1_0_0_1_1);
        chk("bypass", bypass_en, stg < S / 2);
        for (int i = 0; i < 10; i++)
          if (tbl[i].stg == stg && tbl[i].cnt == cnt) begin
            chk("tbl_addr_read", addr_read, rep(tbl[i].ar));
            chk("tbl_tw_idx", tw_idx, tbl[i].tw);
            chk("tbl_bypass", bypass_en, tbl[i].byp);
          end
        sb.push_back('{j + PL, exp_wa(stg, cnt)});
      end
      if (j == start_at) start = 1'b1;
      if (j == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_we", we, 0);
        chk("rst_re", re, 0);
        chk("rst_stage", stage, 0);
        chk("rst_addr_write", addr_write, 0);
        sb.delete();
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("rst_no_pending_we", we, 0);
          chk("rst_stay_idle", busy, 0);
        end
        return;
      end
    end
    chk("sb_drained", sb.size(), 0);
  endtask
  initial begin
    tbl[0] = '{0, 0, 0, 0, 1};
    tbl[1] = '{1, 10, 10, 20, 1};
    tbl[2] = '{2, 5, 37, 20, 1};
    tbl[3] = '{2, 63, 31, 124, 1};
    tbl[4] = '{3, 20, 4, 32, 1};
    tbl[5] = '{4, 10, 2, 32, 0};
    tbl[6] = '{5, 5, 1, 32, 0};
    tbl[7] = '{6, 3, 1, 64, 0};
    tbl[8] = '{7, 1, 0, 0, 0};
    tbl[9] = '{7, 63, 62, 0, 0};
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_en_re_we", {en, re, we}, 0);
    chk("reset_stage", stage, 0);
    chk("reset_addr", {addr_read, addr_write}, 0);
    chk("reset_tw_byp", {tw_idx, bypass_en}, 0);
    rst_n = 1'b1;
    run(0, 0);
    run(H + 2 * (H + PL) + 11, 0);
    run(0, H + (H + PL) + 36);
    run(0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
